adder64_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one instance of the team's 64-bit Ladner-Fischer adder among NREQ requesters. Each accepted request is one 64-bit word operation. Multi-word (multi-precision) operations lock the grant and chain the carry between words. Results leave through a single registered valid/ready port tagged with the requester id.

---
 rtl/adder64_rr_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_adder64_rr_scheduler.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder64_rr_scheduler.sv
// Round-robin scheduler sharing one 64-bit Ladner-Fischer adder among NREQ requesters,
// with grant locking and carry chaining for multi-word operations. Optional: ADDSCHED_SUB_EN.

module adder64_lf (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout
);

  // Parallel-prefix carry network; carry-in is folded into the bit-0 generate term.
  function automatic logic [64:0] lf_add(input logic [63:0] x, input logic [63:0] y,
                                         input logic ci);
    logic [63:0] g;
    logic [63:0] p;
    logic [63:0] p0;
    logic [63:0] c;
    p0   = x ^ y;
    p    = p0;
    g    = x & y;
    g[0] = g[0] | (p[0] & ci);
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 64; i++) begin
        if (((i >> k) & 1) == 1) begin
          g[i] = g[i] | (p[i] & g[((i >> k) << k) - 1]);
          p[i] = p[i] & p[((i >> k) << k) - 1];
        end
      end
    end
    c = {g[62:0], ci};
    return {g[63], p0 ^ c};
  endfunction

  always_comb begin
    {cout, sum} = lf_add(a, b, cin);
  end

endmodule

module adder64_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*64-1:0]   req_a,
  input  logic [NREQ*64-1:0]   req_b,
  input  logic [NREQ-1:0]      req_cin,
  input  logic [NREQ-1:0]      req_last,
`ifdef ADDSCHED_SUB_EN
  input  logic [NREQ-1:0]      req_sub,
`endif
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [63:0]          res_sum,
  output logic                 res_cout,
  output logic [IDW-1:0]       res_id,
  output logic                 res_last
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] lock_id_q, lock_id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic           carry_q, carry_d;
  logic           res_valid_q, res_valid_d;
  logic [63:0]    res_sum_q, res_sum_d;
  logic           res_cout_q, res_cout_d;
  logic [IDW-1:0] res_id_q, res_id_d;
  logic           res_last_q, res_last_d;
`ifdef ADDSCHED_SUB_EN
  logic           sub_q, sub_d;
`endif

  logic           stall;
  logic           grant_found;
  logic [IDW-1:0] grant_id;
  logic           accept;
  logic           first_word;
  logic           sub_eff;
  int             idx;
  logic [63:0]    op_a;
  logic [63:0]    op_b;
  logic           op_cin;
  logic [63:0]    add_sum;
  logic           add_cout;

  assign stall      = res_valid_q & ~res_ready;
  assign first_word = (state_q == IDLE);

  // A locked chain blocks everyone else, even while its owner is idle.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    if (state_q == LOCKED) begin
      grant_found = req_valid[lock_id_q];
      grant_id    = lock_id_q;
    end else begin
      for (int off = 0; off < NREQ; off++) begin
        idx = (int'(ptr_q) + off) % NREQ;
        if (!grant_found && req_valid[idx]) begin
          grant_found = 1'b1;
          grant_id    = IDW'(idx);
        end
      end
    end
  end

  assign accept    = grant_found & ~stall & rst_n;
  assign req_ready = accept ? (NREQ'(1) << grant_id) : '0;

  assign op_a = req_a[int'(grant_id)*64 +: 64];

`ifdef ADDSCHED_SUB_EN
  assign sub_eff = first_word ? req_sub[grant_id] : sub_q;
  assign op_b    = sub_eff ? ~req_b[int'(grant_id)*64 +: 64] : req_b[int'(grant_id)*64 +: 64];
  assign op_cin  = first_word ? (sub_eff | req_cin[grant_id]) : carry_q;
`else
  assign sub_eff = 1'b0;
  assign op_b    = req_b[int'(grant_id)*64 +: 64];
  assign op_cin  = first_word ? req_cin[grant_id] : carry_q;
`endif

  adder64_lf u_adder (
    .a    (op_a),
    .b    (op_b),
    .cin  (op_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d     = state_q;
    lock_id_d   = lock_id_q;
    ptr_d       = ptr_q;
    carry_d     = carry_q;
    res_valid_d = res_valid_q;
    res_sum_d   = res_sum_q;
    res_cout_d  = res_cout_q;
    res_id_d    = res_id_q;
    res_last_d  = res_last_q;
`ifdef ADDSCHED_SUB_EN
    sub_d       = sub_q;
`endif
    if (accept) begin
      carry_d     = add_cout;
      res_valid_d = 1'b1;
      res_sum_d   = add_sum;
      res_cout_d  = add_cout;
      res_id_d    = grant_id;
      res_last_d  = req_last[grant_id];
`ifdef ADDSCHED_SUB_EN
      sub_d       = sub_eff;
`endif
      if (req_last[grant_id]) begin
        state_d = IDLE;
        ptr_d   = IDW'((int'(grant_id) + 1) % NREQ);
      end else begin
        state_d   = LOCKED;
        lock_id_d = grant_id;
      end
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lock_id_q   <= '0;
      ptr_q       <= '0;
      carry_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_cout_q  <= 1'b0;
      res_id_q    <= '0;
      res_last_q  <= 1'b0;
`ifdef ADDSCHED_SUB_EN
      sub_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      lock_id_q   <= lock_id_d;
      ptr_q       <= ptr_d;
      carry_q     <= carry_d;
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_cout_q  <= res_cout_d;
      res_id_q    <= res_id_d;
      res_last_q  <= res_last_d;
`ifdef ADDSCHED_SUB_EN
      sub_q       <= sub_d;
`endif
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_cout  = res_cout_q;
  assign res_id    = res_id_q;
  assign res_last  = res_last_q;

endmodule

// File: tb/tb_adder64_rr_scheduler.sv
// Self-checking bench for adder64_rr_scheduler: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.

module tb_adder64_rr_scheduler;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*64-1:0] req_a = '0;
  logic [NREQ*64-1:0] req_b = '0;
  logic [NREQ-1:0]    req_cin = '0;
  logic [NREQ-1:0]    req_last = '0;
  logic [NREQ-1:0]    req_sub = '0;
  logic               res_valid;
  logic               res_ready = 1'b0;
  logic [63:0]        res_sum;
  logic               res_cout;
  logic [IDW-1:0]     res_id;
  logic               res_last;

  adder64_rr_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_last  (req_last),
`ifdef ADDSCHED_SUB_EN
    .req_sub   (req_sub),
`endif
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_cout  (res_cout),
    .res_id    (res_id),
    .res_last  (res_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: what the output register should hold, plus arbitration/chain state.
  logic        m_locked = 1'b0;
  int          m_owner  = 0;
  int          m_ptr    = 0;
  logic        m_carry  = 1'b0;
  logic        m_sub    = 1'b0;
  logic        m_valid  = 1'b0;
  logic [63:0] m_sum    = '0;
  logic        m_cout   = 1'b0;
  int          m_id     = 0;
  logic        m_last   = 1'b0;

  logic [255:0] vec_a, vec_b;
  logic [63:0]  held_sum;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic modelReset();
    m_locked = 1'b0; m_owner = 0; m_ptr = 0; m_carry = 1'b0; m_sub = 1'b0;
    m_valid = 1'b0; m_sum = '0; m_cout = 1'b0; m_id = 0; m_last = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = NREQ'($urandom);
    res_ready = 1'b1;
    #1;
    checkOutput("ready_in_reset", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    modelReset();
  endtask

  // One cycle: drive at negedge, compare DUT to model, then advance the model past the next edge.
  task automatic applyStimulus(input logic [3:0] v, input logic [255:0] a, input logic [255:0] b,
                               input logic [3:0] cin, input logic [3:0] last,
                               input logic [3:0] sub, input logic rr);
    int          g;
    logic [3:0]  exp_ready;
    logic        first, s, ci;
    logic [63:0] ai, bi;
    logic [64:0] full;
    @(negedge clk);
    req_valid = v; req_a = a; req_b = b; req_cin = cin; req_last = last; req_sub = sub;
    res_ready = rr;
    #1;
    checkOutput("res_valid", 64'(res_valid), 64'(m_valid));
    checkOutput("res_sum", res_sum, m_sum);
    checkOutput("res_cout", 64'(res_cout), 64'(m_cout));
    checkOutput("res_id", 64'(res_id), 64'(m_id));
    checkOutput("res_last", 64'(res_last), 64'(m_last));
    g = -1;
    if (!(m_valid && !rr)) begin
      if (m_locked) begin
        if (v[m_owner]) g = m_owner;
      end else begin
        for (int off = 0; off < NREQ; off++)
          if (g < 0 && v[(m_ptr + off) % NREQ]) g = (m_ptr + off) % NREQ;
      end
    end
    exp_ready = (g >= 0) ? 4'(1 << g) : 4'd0;
    checkOutput("req_ready", 64'(req_ready), 64'(exp_ready));
    if (g >= 0) begin
      first = !m_locked;
`ifdef ADDSCHED_SUB_EN
      s = first ? sub[g] : m_sub;
`else
      s = 1'b0;
`endif
      ci   = first ? (s ? 1'b1 : cin[g]) : m_carry;
      ai   = a[g*64 +: 64];
      bi   = s ? ~b[g*64 +: 64] : b[g*64 +: 64];
      full = {1'b0, ai} + {1'b0, bi} + 65'(ci);
      m_sum = full[63:0]; m_cout = full[64]; m_carry = full[64];
      m_id = g; m_last = last[g]; m_valid = 1'b1;
      if (first) m_sub = s;
      if (last[g]) begin
        m_locked = 1'b0;
        m_ptr    = (g + 1) % NREQ;
      end else begin
        m_locked = 1'b1;
        m_owner  = g;
      end
    end else if (rr) begin
      m_valid = 1'b0;
    end
  endtask

  function automatic logic [63:0] rand64();
    case ($urandom_range(0, 7))
      0:       return '1;
      1:       return '0;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  function automatic logic [255:0] rand256();
    return {rand64(), rand64(), rand64(), rand64()};
  endfunction

  initial begin
    doReset();

    vec_a = '0; vec_b = '0;
    vec_a[63:0] = 64'd15; vec_b[63:0] = 64'd10;
    applyStimulus(4'b0001, vec_a, vec_b, 4'b0001, 4'b1111, 4'b0000, 1'b1);
    checkOutput("single_grant", 64'(req_ready), 64'h1);
    applyStimulus(4'b0000, vec_a, vec_b, 4'b0000, 4'b1111, 4'b0000, 1'b1);
    checkOutput("single_valid", 64'(res_valid), 64'd1);
    checkOutput("single_sum", res_sum, 64'd26);
    checkOutput("single_cout", 64'(res_cout), 64'd0);
    checkOutput("single_id", 64'(res_id), 64'd0);

    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b1111, rand256(), rand256(), 4'(NREQ'($urandom)), 4'b1111, 4'b0000, 1'b1);
      checkOutput("fair_grant", 64'(req_ready), 64'(1 << (i % 4)));
    end

    applyStimulus(4'b0010, rand256(), rand256(), 4'b0000, 4'b1111, 4'b0000, 1'b1);
    vec_a = '0; vec_b = '0;
    vec_a[191:128] = '1; vec_b[191:128] = 64'd1;
    applyStimulus(4'b0110, vec_a, vec_b, 4'b0000, 4'b1011, 4'b0000, 1'b1);
    checkOutput("chain_w0_grant", 64'(req_ready), 64'h4);
    vec_a = '0; vec_b = '0;
    applyStimulus(4'b0110, vec_a, vec_b, 4'b0000, 4'b1111, 4'b0000, 1'b1);
    checkOutput("chain_w1_grant", 64'(req_ready), 64'h4);
    checkOutput("chain_w0_sum", res_sum, 64'd0);
    checkOutput("chain_w0_cout", 64'(res_cout), 64'd1);
    checkOutput("chain_w0_id", 64'(res_id), 64'd2);
    applyStimulus(4'b0010, vec_a, vec_b, 4'b0000, 4'b1111, 4'b0000, 1'b1);
    checkOutput("chain_req1_grant", 64'(req_ready), 64'h2);
    checkOutput("chain_w1_sum", res_sum, 64'd1);
    checkOutput("chain_w1_cout", 64'(res_cout), 64'd0);
    checkOutput("chain_w1_last", 64'(res_last), 64'd1);

    applyStimulus(4'b1111, rand256(), rand256(), 4'b0000, 4'b1111, 4'b0000, 1'b0);
    held_sum = res_sum;
    checkOutput("bp_ready", 64'(req_ready), 64'd0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(4'b1111, rand256(), rand256(), 4'b1111, 4'b1111, 4'b0000, 1'b0);
      checkOutput("bp_ready", 64'(req_ready), 64'd0);
      checkOutput("bp_sum_hold", res_sum, held_sum);
      checkOutput("bp_id_hold", 64'(res_id), 64'd1);
    end
    applyStimulus(4'b1111, rand256(), rand256(), 4'b0000, 4'b1111, 4'b0000, 1'b1);
    checkOutput("bp_release_grant", 64'(req_ready), 64'h4);

    doReset();
    vec_a = '0; vec_b = '0;
    vec_a[255:192] = '1; vec_b[255:192] = 64'd1;
    applyStimulus(4'b1000, vec_a, vec_b, 4'b0000, 4'b0111, 4'b0000, 1'b1);
    checkOutput("midreset_w0_grant", 64'(req_ready), 64'h8);
    doReset();
    applyStimulus(4'b0000, vec_a, vec_b, 4'b0000, 4'b1111, 4'b0000, 1'b1);
    checkOutput("midreset_valid", 64'(res_valid), 64'd0);
    vec_a = '0; vec_b = '0;
    vec_a[255:192] = 64'd5; vec_b[255:192] = 64'd6;
    applyStimulus(4'b1000, vec_a, vec_b, 4'b1000, 4'b1111, 4'b0000, 1'b1);
    applyStimulus(4'b0000, vec_a, vec_b, 4'b0000, 4'b1111, 4'b0000, 1'b1);
    checkOutput("midreset_sum", res_sum, 64'd12);

`ifdef ADDSCHED_SUB_EN
    doReset();
    vec_a = '0; vec_b = '0;
    vec_a[63:0] = 64'd10; vec_b[63:0] = 64'd15;
    applyStimulus(4'b0001, vec_a, vec_b, 4'b0000, 4'b1111, 4'b0001, 1'b1);
    applyStimulus(4'b0000, vec_a, vec_b, 4'b0000, 4'b1111, 4'b0000, 1'b1);
    checkOutput("sub_sum", res_sum, 64'hFFFF_FFFF_FFFF_FFFB);
    checkOutput("sub_cout", 64'(res_cout), 64'd0);
`endif

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        doReset();
      end else begin
        applyStimulus(4'($urandom_range(0, 15) | $urandom_range(0, 15)), rand256(), rand256(),
                      4'($urandom), 4'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
